// File: rtl/jump_branch_sequencer.sv
`timescale 1ns/1ps
// jump_branch_sequencer
// Moore control sequencer for the fetch cycle plus the jr, jal and conditional
// branch instructions. Every strobe is decoded from the state register (and,
// in T1, from the memory wait counter), so outputs never depend on inputs
// except con_ff, which is sampled only in BR6.
module jump_branch_sequencer #(
    parameter int unsigned MEM_WAIT = 0,
    parameter logic [4:0]  OP_JR    = 5'b10011,
    parameter logic [4:0]  OP_JAL   = 5'b10100,
    parameter logic [4:0]  OP_BR    = 5'b10010,
    parameter bit          CONT     = 1'b0
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       run,
    input  logic [4:0] opcode,
    input  logic       con_ff,
    output logic       PC_out,
    output logic       MAR_rd,
    output logic       Zlo_rd,
    output logic       IncPC,
    output logic       Zlo_out,
    output logic       PC_rd,
    output logic       Read,
    output logic       MDR_rd,
    output logic       MDR_out,
    output logic       IR_rd,
    output logic       Gra,
    output logic       R_out,
    output logic       Rin,
    output logic       CONin,
    output logic       Y_rd,
    output logic       C_out,
    output logic       lnk_sel,
    output logic       alu_add,
    output logic       busy,
    output logic       done,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        T0   = 4'd1,
        T1   = 4'd2,
        T2   = 4'd3,
        DEC  = 4'd4,
        JR3  = 4'd5,
        JAL3 = 4'd6,
        JAL4 = 4'd7,
        BR3  = 4'd8,
        BR4  = 4'd9,
        BR5  = 4'd10,
        BR6  = 4'd11,
        ILL  = 4'd12,
        DONE = 4'd13
    } state_t;

    localparam logic [2:0] WAIT_INIT = MEM_WAIT[2:0];

    state_t     state_q, state_d;
    logic [2:0] wait_q, wait_d;

    assign state = state_q;

    // State and wait-counter registers; clr clears both immediately.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= IDLE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Next-state and strobe decode from the current state.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        PC_out  = 1'b0;
        MAR_rd  = 1'b0;
        Zlo_rd  = 1'b0;
        IncPC   = 1'b0;
        Zlo_out = 1'b0;
        PC_rd   = 1'b0;
        Read    = 1'b0;
        MDR_rd  = 1'b0;
        MDR_out = 1'b0;
        IR_rd   = 1'b0;
        Gra     = 1'b0;
        R_out   = 1'b0;
        Rin     = 1'b0;
        CONin   = 1'b0;
        Y_rd    = 1'b0;
        C_out   = 1'b0;
        lnk_sel = 1'b0;
        alu_add = 1'b0;
        done    = 1'b0;
        illegal = 1'b0;
        busy    = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (run) state_d = T0;
            end
            T0: begin
                PC_out  = 1'b1;
                MAR_rd  = 1'b1;
                IncPC   = 1'b1;
                Zlo_rd  = 1'b1;
                wait_d  = WAIT_INIT;
                state_d = T1;
            end
            T1: begin
                Read   = 1'b1;
                MDR_rd = 1'b1;
                // Counter still holds its load value only on the first T1 cycle.
                if (wait_q == WAIT_INIT) begin
                    Zlo_out = 1'b1;
                    PC_rd   = 1'b1;
                end
                if (wait_q == 3'd0) state_d = T2;
                else                wait_d  = wait_q - 3'd1;
            end
            T2: begin
                MDR_out = 1'b1;
                IR_rd   = 1'b1;
                state_d = DEC;
            end
            DEC: begin
                if      (opcode == OP_JR)  state_d = JR3;
                else if (opcode == OP_JAL) state_d = JAL3;
                else if (opcode == OP_BR)  state_d = BR3;
                else                       state_d = ILL;
            end
            JR3: begin
                Gra     = 1'b1;
                R_out   = 1'b1;
                PC_rd   = 1'b1;
                state_d = DONE;
            end
            JAL3: begin
                PC_out  = 1'b1;
                Rin     = 1'b1;
                lnk_sel = 1'b1;
                state_d = JAL4;
            end
            JAL4: begin
                Gra     = 1'b1;
                R_out   = 1'b1;
                PC_rd   = 1'b1;
                state_d = DONE;
            end
            BR3: begin
                Gra     = 1'b1;
                R_out   = 1'b1;
                CONin   = 1'b1;
                state_d = BR4;
            end
            BR4: begin
                PC_out  = 1'b1;
                Y_rd    = 1'b1;
                state_d = BR5;
            end
            BR5: begin
                C_out   = 1'b1;
                alu_add = 1'b1;
                Zlo_rd  = 1'b1;
                state_d = BR6;
            end
            BR6: begin
                if (con_ff) begin
                    Zlo_out = 1'b1;
                    PC_rd   = 1'b1;
                end
                state_d = DONE;
            end
            ILL: begin
                illegal = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = (CONT && run) ? T0 : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
